// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
//   parity_t   : parity selection (none / even / odd)
//   tx_state_t : transmit FSM state encoding
//   MIN_DATA_BITS / MAX_DATA_BITS : legal data-bit range
package uart_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset (flushes contents)
//   push_i, wdata_i   : write request and data (ignored when full)
//   pop_i, rdata_o    : read request (ignored when empty) and head-of-queue data
//   full_o, empty_o   : occupancy flags
//   level_o           : number of stored entries
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic                  do_push_c;
  logic                  do_pop_c;

  assign do_push_c = push_i && !full_o;
  assign do_pop_c  = pop_i && !empty_o;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are invalidated by the pointer reset.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter with runtime frame format and baud divider.
// Optional feature macro: UART_TX_FIFO_EN (FIFO_DEPTH-entry TX FIFO and
// fifo_level port); without it a single holding register buffers writes.
// Ports:
//   clk_16mhz, rst          : clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready : input handshake, LSB transmitted first
//   baud_div                : bit period is baud_div+1 clocks
//   data_bits               : data bits per frame, clamped to 5..DATA_WIDTH
//   parity_mode, two_stop   : parity selection and stop-bit count
//   busy, tx_done           : frame in progress / one-cycle end-of-frame pulse
//   serial_out              : TX line, idles high
//   fifo_level              : FIFO occupancy (FIFO build only)
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
`ifdef UART_TX_FIFO_EN
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`endif
  input  logic                  clk_16mhz,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [3:0]            data_bits,
  input  parity_t               parity_mode,
  input  logic                  two_stop,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  serial_out
);

  localparam logic [3:0]            MIN_BITS = 4'(MIN_DATA_BITS);
  localparam logic [3:0]            MAX_BITS = 4'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONES     = '1;

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH < MIN_DATA_BITS || DATA_WIDTH > MAX_DATA_BITS) begin : g_bad_width
    $error("uart_tx_engine: DATA_WIDTH out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_engine: FIFO_DEPTH must be a power of two >= 2");
  end

  // Storage abstraction seen by the FSM
  logic                  avail_c;
  logic [DATA_WIDTH-1:0] head_data_c;
  logic                  pop_c;
  logic                  push_c;

`ifdef UART_TX_FIFO_EN
  logic fifo_full_c;
  logic fifo_empty_c;

  assign tx_ready = !fifo_full_c;
  assign push_c   = tx_valid && tx_ready;
  assign avail_c  = !fifo_empty_c;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_16mhz),
    .rst_i   (rst),
    .push_i  (push_c),
    .wdata_i (tx_data),
    .pop_i   (pop_c),
    .rdata_o (head_data_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .level_o (fifo_level)
  );
`else
  logic                  hold_valid_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  assign tx_ready    = !hold_valid_q;
  assign push_c      = tx_valid && tx_ready;
  assign avail_c     = hold_valid_q;
  assign head_data_c = hold_data_q;

  // Holding register; push and pop are mutually exclusive by construction.
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (push_c) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= tx_data;
    end else if (pop_c) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // Frame-format decode of the live configuration, used when a word is popped
  logic [3:0]            nbits_c;
  logic [DATA_WIDTH-1:0] mask_c;
  logic                  par_raw_c;

  always_comb begin
    nbits_c = data_bits;
    if (data_bits < MIN_BITS)      nbits_c = MIN_BITS;
    else if (data_bits > MAX_BITS) nbits_c = MAX_BITS;
    mask_c    = ~(ONES << nbits_c);
    par_raw_c = ^(head_data_c & mask_c);
  end

  tx_state_t             state_q,    state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q,      div_d;
  logic [3:0]            bit_cnt_q,  bit_cnt_d;
  logic [3:0]            nbits_q,    nbits_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_bit_q,  par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  serial_q,   serial_d;
  logic                  done_q,     done_d;
  logic                  busy_q,     busy_d;
  logic                  tick_c;

  assign tick_c = (baud_cnt_q == div_q);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    data_d     = data_q;
    serial_d   = serial_q;
    done_d     = 1'b0;
    pop_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        serial_d   = 1'b1;
        if (avail_c) begin
          pop_c    = 1'b1;
          state_d  = ST_START;
          serial_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d    = ST_DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          serial_d   = data_q[0];
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == nbits_q - 4'd1) begin
            if (par_en_q) begin
              state_d  = ST_PARITY;
              serial_d = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              serial_d   = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            // Shift so the next bit to send is always at index 1 -> 0.
            bit_cnt_d = bit_cnt_q + 4'd1;
            data_d    = data_q >> 1;
            serial_d  = data_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          state_d    = ST_STOP;
          baud_cnt_d = '0;
          serial_d   = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          baud_cnt_d = '0;
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (avail_c) begin
              pop_c    = 1'b1;
              state_d  = ST_START;
              serial_d = 1'b0;
            end else begin
              state_d  = ST_IDLE;
              serial_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Latch the word and the frame format at pop time.
    if (pop_c) begin
      baud_cnt_d = '0;
      div_d      = baud_div;
      nbits_d    = nbits_c;
      par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_d  = (parity_mode == PAR_ODD) ? ~par_raw_c : par_raw_c;
      two_stop_d = two_stop;
      data_d     = head_data_c;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= MIN_BITS;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      data_q     <= data_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_done    = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (both storage builds).
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DIVW  = 16;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [DIVW-1:0] baud_div;
  logic [3:0]      data_bits;
  parity_t         parity_mode;
  logic            two_stop;
  logic            busy;
  logic            tx_done;
  logic            serial_out;
`ifdef UART_TX_FIFO_EN
  logic [$clog2(DEPTH):0] fifo_level;
`endif

  uart_tx_engine #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DIVW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
`ifdef UART_TX_FIFO_EN
    .fifo_level  (fifo_level),
`endif
    .clk_16mhz   (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .busy        (busy),
    .tx_done     (tx_done),
    .serial_out  (serial_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  // Expected line waveform of one frame, LSB-first bit list.
  typedef struct {
    logic [15:0] bits;
    int          len;
    int          period;
    int          acc;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en   = 1'b0;
  bit   mon_busy = 1'b0;
  int   last_end = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: frame built from the current configuration inputs.
  function automatic exp_t build(input logic [7:0] d, input int acc);
    exp_t e;
    int   n;
    logic p;
    n = int'(data_bits);
    if (n < 5) n = 5;
    if (n > 8) n = 8;
    e.data   = d;
    e.acc    = acc;
    e.period = int'(baud_div) + 1;
    e.bits   = 16'hFFFF;
    e.bits   = e.bits & ~16'h0001;
    e.len    = 1;
    p        = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (1'(d >> i) == 1'b0) e.bits = e.bits & ~(16'h0001 << e.len);
      p = p ^ 1'(d >> i);
      e.len++;
    end
    if (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) begin
      if (parity_mode == PAR_ODD) p = ~p;
      if (p == 1'b0) e.bits = e.bits & ~(16'h0001 << e.len);
      e.len++;
    end
    e.len += two_stop ? 2 : 1;
    return e;
  endfunction

  // Check one frame starting at the current negedge (line already low).
  task automatic run_frame(output bit aborted);
    exp_t        e;
    int          want;
    int          total;
    int          b;
    bit          bad;
    logic [15:0] obs;
    logic        exp_bit;
    aborted  = 1'b0;
    mon_busy = 1'b1;
    e        = exp_q.pop_front();
    want     = (e.acc + 1 > last_end) ? e.acc + 1 : last_end;
    chk("start_cycle", cyc, want);
    total = e.len * e.period;
    bad   = 1'b0;
    obs   = '0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      if (!mon_en || rst) begin
        aborted  = 1'b1;
        mon_busy = 1'b0;
        return;
      end
      b       = c / e.period;
      exp_bit = 1'(e.bits >> b);
      if (c % e.period == 0) obs = obs | (16'(serial_out) << b);
      if (serial_out !== exp_bit || busy !== 1'b1 || (c > 0 && tx_done !== 1'b0)) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL frame data=%02h: got bits %b want %b (len %0d, period %0d)",
               e.data, obs, e.bits, e.len, e.period);
    end
    @(negedge clk);
    if (!mon_en || rst) begin
      aborted  = 1'b1;
      mon_busy = 1'b0;
      return;
    end
    chk("tx_done_at_end", tx_done, 1);
    last_end = cyc;
    mon_busy = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a start bit appears.
  initial begin : monitor
    bit skip;
    bit ab;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (mon_en && !rst && serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: line low at cycle %0d with nothing queued", cyc);
          for (int i = 0; i < 4000 && serial_out === 1'b0; i++) @(negedge clk);
        end else begin
          run_frame(ab);
          if (!ab) skip = 1'b1;
        end
      end
    end
  end

`ifdef UART_TX_FIFO_EN
  bit lvl_chk  = 1'b0;
  int max_lvl  = 0;
  bit saw_full = 1'b0;
  initial begin : level_watch
    forever begin
      @(negedge clk);
      if (lvl_chk) begin
        chk("ready_vs_level", tx_ready, 32'(fifo_level < DEPTH));
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (!tx_ready) saw_full = 1'b1;
      end
    end
  end
`endif

  // Drive one word; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d);
    logic rdy;
    int   waited;
    waited   = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    forever begin
      rdy = tx_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      waited++;
      if (waited > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: tx_ready stayed 0 for %0d cycles", waited);
        tx_valid = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    exp_q.push_back(build(d, cyc));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && busy === 1'b0 && tx_ready === 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: %0d frames still expected", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input int nb, input parity_t pm, input bit two);
    baud_div    = DIVW'(div);
    data_bits   = 4'(nb);
    parity_mode = pm;
    two_stop    = two;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit quiet;
    int n;
    tx_valid = 1'b0;
    tx_data  = '0;
    set_cfg(3, 8, PAR_NONE, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("reset_serial_out", serial_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_tx_ready", tx_ready, 1);
`ifdef UART_TX_FIFO_EN
    chk("reset_fifo_level", 32'(fifo_level), 0);
`endif
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed frame formats
    send(8'hA5);
    wait_drain();
    set_cfg(0, 7, PAR_EVEN, 1'b1);
    send(8'h55);
    wait_drain();
    set_cfg(0, 7, PAR_ODD, 1'b1);
    send(8'h55);
    wait_drain();
    set_cfg(1, 2, PAR_EVEN, 1'b0);
    send(8'hF3);
    wait_drain();
    set_cfg(2, 15, PAR_ODD, 1'b0);
    send(8'hC6);
    wait_drain();

`ifdef UART_TX_FIFO_EN
    // Burst into the FIFO while busy; frames must chain with no gap.
    set_cfg(7, 8, PAR_NONE, 1'b0);
    lvl_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)));
    lvl_chk = 1'b0;
    chk("fifo_max_level", max_lvl, DEPTH);
    chk("fifo_saw_not_ready", 32'(saw_full), 1);
    wait_drain();
`else
    // Holding register: ready drops after the write and returns after the pop.
    set_cfg(2, 8, PAR_NONE, 1'b0);
    send(8'h3A);
    chk("ready_after_push", tx_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", tx_ready, 1);
    send(8'hC5);
    wait_drain();
`endif

    // Randomised configurations and word spacing
    for (int g = 0; g < 8; g++) begin
      wait_drain();
      set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
              parity_t'(2'($urandom_range(0, 2))), 1'($urandom_range(0, 1)));
      for (int w = 0; w < 4; w++) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        send(8'($urandom));
      end
    end
    wait_drain();

    // Reset in the middle of the data bits
    set_cfg(3, 8, PAR_NONE, 1'b0);
    send(8'hF0);
    send(8'h0F);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midframe_rst_serial", serial_out, 1);
    chk("midframe_rst_busy", busy, 0);
    chk("midframe_rst_done", tx_done, 0);
    chk("midframe_rst_ready", tx_ready, 1);
`ifdef UART_TX_FIFO_EN
    chk("midframe_rst_level", 32'(fifo_level), 0);
`endif
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("quiet_after_reset", 32'(quiet), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmitter that supersedes the fixed 8N1 TX controller. It adds runtime-selectable frame format (5..DATA_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits), an internal integer baud divider, and a valid/ready input handshake. An optional transmit FIFO supports back-to-back frames. It sits between the core's UART register block and the TX pin.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame; legal range 5..9.
- DIV_WIDTH, 16: width of the baud divisor.
- FIFO_DEPTH, 8: TX FIFO entries, a power of two ≥ 2; used only with UART_TX_FIFO_EN.
- clk_16mhz  input  1  system clock. One clock only.
- rst  input  1  reset, synchronous, active-high.
- tx_data  input  DATA_WIDTH  frame payload, LSB sent first.
- tx_valid  input  1  payload valid.
- tx_ready  output  1  engine can accept; a transfer occurs when tx_valid && tx_ready.
- baud_div  input  DIV_WIDTH  bit period is baud_div+1 clocks.
- data_bits  input  4  data bits per frame. Values <5 act as 5; values >DATA_WIDTH act as DATA_WIDTH.
- parity_mode  input  parity_t  PAR_NONE / PAR_EVEN / PAR_ODD.
- two_stop  input  1  0 selects 1 stop bit; 1 selects 2 stop bits.
- busy  output  1  a frame is on the line.
- tx_done  output  1  one-cycle pulse at the end of each frame.
- serial_out  output  1  TX line; idles high.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy. Present only with UART_TX_FIFO_EN.

## Operation
- Reset values: serial_out=1, busy=0, tx_done=0, tx_ready=1, fifo_level=0. Reset also flushes any stored data.
- Storage:
  - Without the FIFO: a single holding register. tx_ready = holding register empty.
  - With the FIFO: tx_ready = !full.
- The FSM has states IDLE, START, DATA, PARITY, STOP.
- IDLE: when stored data is available, on the next edge the FSM pops the word, latches baud_div, data_bits, parity_mode and two_stop, drives serial_out=0, clears the baud and bit counters, and goes to START. Configuration changes during a frame have no effect until the next frame.
- Every state holds for baud_div+1 clocks, counted by baud_cnt. The transition happens on the edge where baud_cnt == latched divisor.
- START -> DATA. DATA sends bits 0..N-1 of the latched word, then goes to PARITY if parity is enabled, else to STOP.
- PARITY bit value:
  - PAR_EVEN: XOR of the N sent bits.
  - PAR_ODD: inverted XOR of the N sent bits.
  - Bits above N are ignored.
- STOP drives 1 for 1 or 2 bit periods.
- At the end of the final stop period, tx_done pulses for exactly one cycle. Then:
  - if more data is stored, the FSM goes directly to START (no idle gap; the new word is popped on that same edge);
  - otherwise it goes to IDLE.
- busy=1 in every state except IDLE.
- Frame length in clocks = (baud_div+1)·(1+N+P+S).

## Timing
- Push: a write on cycle k is visible to the FSM at k+1. serial_out falls at the earliest on the edge ending cycle k+1, so start-bit latency is 2 clocks from an accepted write when IDLE.
- Simultaneous push and pop on a full FIFO: the pop frees a slot but tx_ready is computed from the current state, so the push is not accepted that cycle.
- Simultaneous push and pop on a non-full FIFO: both happen, and fifo_level is unchanged.
- Non-FIFO build: the holding register empties on the pop edge, so tx_ready rises one cycle later.
- baud_div=0 gives one clock per bit; this is legal.
- Reset asserted mid-frame: on the next edge serial_out=1 and the FSM returns to IDLE. tx_done is not pulsed.
- Pointer wrap: FIFO pointers carry one extra MSB so full and empty can be distinguished. Wrap-around is seamless.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO buffers writes, and the fifo_level port exists.
- UART_TX_FIFO_EN undefined: a single holding register buffers writes, the fifo_level port is absent, and FIFO_DEPTH is unused. The FSM and line behaviour are otherwise identical.

## Structure
- uart_pkg holds:
  - parity_t (2-bit enum);
  - the tx_state_t FSM enum;
  - constants MIN_DATA_BITS=5 and MAX_DATA_BITS=9.
- Sub-module uart_tx_fifo, a synchronous FIFO with push, pop, full, empty and level. It is instantiated only under UART_TX_FIFO_EN.

## Test plan
- baud_div=3, 8 data bits, PAR_NONE, 1 stop, write 0xA5 -> serial_out low 4 clks, then 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks. tx_done pulses once, 40 clks after the start bit falls.
- baud_div=0, 7 bits, PAR_EVEN, 2 stop, write 0x55 -> bits 1,0,1,0,1,0,1, parity bit 0, two stop bits; 11 clks total.
- Same frame with PAR_ODD and 0x55 -> parity bit 1. data_bits=2 behaves as 5 bits.
- FIFO build, FIFO_DEPTH=4, 6 writes while busy -> tx_ready drops at fifo_level=4. All frames go out back-to-back with no idle gap, in order, and tx_done pulses 6 times.
- Non-FIFO build, two writes -> tx_ready low until the first pop. The second frame's start bit directly follows the first frame's stop bit.
- rst asserted mid-DATA -> serial_out=1, busy=0 and fifo_level=0 next cycle. No tx_done pulse, and nothing further is transmitted.
